// File: rtl/jump_traj_gen.sv
// Parametrised jump-trajectory generator: integrates a vertical velocity under
// constant gravity on each i_tick, tracks horizontal distance, and reports apex/landing.
module jump_traj_gen #(
  parameter int unsigned V_W  = 11,
  parameter int unsigned H_W  = 9,
  parameter int unsigned D_W  = 11,
  parameter int unsigned GRAV = 1,
  parameter int unsigned DX   = 2
) (
  input  logic           clk_machine,
  input  logic           rst_machine,
  input  logic           i_tick,
  input  logic           i_start,
  input  logic [V_W-1:0] i_v_init,
  input  logic           i_abort,
  output logic [H_W-1:0] o_height,
  output logic [D_W-1:0] o_dist,
  output logic           o_busy,
  output logic           o_apex,
  output logic           o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL,
    ST_DONE
  } state_e;

  localparam int unsigned SW = ((H_W > V_W) ? H_W : V_W) + 1;
  localparam int unsigned CW = (H_W > V_W + 1) ? H_W : V_W + 1;
  localparam logic [H_W-1:0] H_MAX  = '1;
  localparam logic [D_W-1:0] D_MAX  = '1;
  localparam logic [V_W:0]   GRAV_X = (V_W+1)'(GRAV);
  localparam logic [D_W:0]   DX_X   = (D_W+1)'(DX);

  state_e         state_q, state_d;
  logic [V_W-1:0] v_q, v_d;
  logic [H_W-1:0] h_q, h_d;
  logic [D_W-1:0] d_q, d_d;
  logic           busy_q, busy_d;
  logic           apex_q, apex_d;
  logic           done_q, done_d;

  logic [SW-1:0]  h_sum;
  logic [H_W-1:0] h_rise;
  logic [D_W:0]   d_sum;
  logic [D_W-1:0] d_step;
  logic [V_W:0]   v_x;
  logic [V_W:0]   vn;
  logic [V_W-1:0] vn_sat;
  logic [V_W-1:0] v_dec;
  logic [CW-1:0]  h_cmp;
  logic [CW-1:0]  vn_cmp;
  logic [CW-1:0]  h_diff;
  logic           apex_hit;
  logic           land_hit;

  // Arithmetic is done one bit wider than the stored values so every step can saturate instead of wrapping.
  always_comb begin
    h_sum    = SW'(h_q) + SW'(v_q);
    h_rise   = (h_sum > SW'(H_MAX)) ? H_MAX : h_sum[H_W-1:0];
    d_sum    = {1'b0, d_q} + DX_X;
    d_step   = d_sum[D_W] ? D_MAX : d_sum[D_W-1:0];
    v_x      = {1'b0, v_q};
    apex_hit = (v_x <= GRAV_X);
    v_dec    = V_W'(v_x - GRAV_X);
    vn       = v_x + GRAV_X;
    vn_sat   = vn[V_W] ? '1 : vn[V_W-1:0];
    h_cmp    = CW'(h_q);
    vn_cmp   = CW'(vn);
    land_hit = (h_cmp <= vn_cmp);
    h_diff   = h_cmp - vn_cmp;
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    d_d     = d_q;
    apex_d  = 1'b0;
    done_d  = 1'b0;
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      h_d     = '0;
      v_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            v_d     = i_v_init;
            h_d     = '0;
            d_d     = '0;
            state_d = (i_v_init != '0) ? ST_RISE : ST_DONE;
          end
        end
        ST_RISE: begin
          if (i_tick) begin
            h_d = h_rise;
            d_d = d_step;
            if (apex_hit) begin
              v_d     = '0;
              apex_d  = 1'b1;
              state_d = ST_FALL;
            end else begin
              v_d = v_dec;
            end
          end
        end
        ST_FALL: begin
          if (i_tick) begin
            d_d = d_step;
            if (land_hit) begin
              h_d     = '0;
              v_d     = '0;
              state_d = ST_DONE;
            end else begin
              h_d = h_diff[H_W-1:0];
              v_d = vn_sat;
            end
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RISE) || (state_d == ST_FALL);
  end

  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      h_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      apex_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      h_q     <= h_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      apex_q  <= apex_d;
      done_q  <= done_d;
    end
  end

  assign o_height = h_q;
  assign o_dist   = d_q;
  assign o_busy   = busy_q;
  assign o_apex   = apex_q;
  assign o_done   = done_q;

endmodule
